// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Brief    : Valid/ready pipeline register chain of DEPTH stages with bubble
//            collapsing, optional input skid register for a registered
//            ready_o, synchronous flush and a registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1,
   parameter int SKID  = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+2)-1:0] count_o
);

   localparam int C_CNT_W = $clog2(DEPTH+2);

   // Stage state: valid bits packed, payloads as an unpacked array
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   // Per-stage advance enables
   logic [DEPTH-1:0] w_cke;

   // Source feeding stage 0 (input port or skid entry)
   logic             w_src_v;
   logic [WIDTH-1:0] w_src_d;

   // Port-level handshakes used by the occupancy counter
   logic             w_up_xfer;
   logic             w_dn_xfer;

   logic [C_CNT_W-1:0] count_q;
   logic [C_CNT_W-1:0] count_d;

   // Stage k may advance if any stage from k to the output is empty, or the
   // consumer is ready. Written as a flat OR so it has no self-dependency.
   always_comb begin
      w_cke = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_cke[k] = ready_i;
         for (int j = k; j < DEPTH; j++) begin
            w_cke[k] = w_cke[k] | ~v_q[j];
         end
      end
   end

   // Next state of every stage: load from upstream when enabled, hold
   // otherwise; flush kills all valids but leaves payloads untouched.
   always_comb begin
      v_d = v_q;
      for (int k = 0; k < DEPTH; k++) begin
         d_d[k] = d_q[k];
      end

      if (w_cke[0]) begin
         v_d[0] = w_src_v;
         if (w_src_v) begin
            d_d[0] = w_src_d;
         end
      end

      for (int k = 1; k < DEPTH; k++) begin
         if (w_cke[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               d_d[k] = d_q[k-1];
            end
         end
      end

      if (flush_i) begin
         v_d = '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
         end
      end
   end

   // Stage registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic             skv_q;
         logic             skv_d;
         logic [WIDTH-1:0] skd_q;
         logic [WIDTH-1:0] skd_d;

         // Skid captures an accepted item that stage 0 cannot take, and
         // releases it into stage 0 as soon as stage 0 advances.
         always_comb begin
            skv_d = skv_q;
            skd_d = skd_q;
            if (flush_i) begin
               skv_d = 1'b0;
            end else if (!skv_q && valid_i && !w_cke[0]) begin
               skv_d = 1'b1;
               skd_d = data_i;
            end else if (skv_q && w_cke[0]) begin
               skv_d = 1'b0;
            end
         end

         // Skid register, cleared asynchronously
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skv_q <= 1'b0;
               skd_q <= '0;
            end else begin
               skv_q <= skv_d;
               skd_q <= skd_d;
            end
         end

         // A held skid entry always has priority over the input port
         assign w_src_v = skv_q | valid_i;
         assign w_src_d = skv_q ? skd_q : data_i;
         assign ready_o = ~skv_q;
      end else begin : g_noskid
         assign w_src_v = valid_i;
         assign w_src_d = data_i;
         assign ready_o = w_cke[0];
      end
   endgenerate

   assign w_up_xfer = valid_i & ready_o;
   assign w_dn_xfer = valid_o & ready_i;

   // Occupancy follows the port handshakes; flush empties everything
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else begin
         count_d = count_q + C_CNT_W'(w_up_xfer) - C_CNT_W'(w_dn_xfer);
      end
   end

   // Occupancy register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign valid_o = v_q[DEPTH-1];
   assign data_o  = d_q[DEPTH-1];
   assign count_o = count_q;

endmodule
`default_nettype wire
